// File: rtl/lenet_argmax_pkg.sv
// Shared types and constants for the LeNet classifier output stage.
package lenet_argmax_pkg;

   localparam int NUM_CLASS = 10;
   localparam int LOGIT_W   = 8;
   localparam int LANES     = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_RESOLVE,
      ST_HOLD
   } state_t;

   typedef struct packed {
      logic       valid;
      logic [1:0] lane;
   } lane_sel_t;

   // Decode an active-low byte mask: lane of the single 0 bit, valid only if exactly one lane is active.
   function automatic lane_sel_t lane_of(input logic [LANES-1:0] mask);
      lane_sel_t r;
      int        zeros;
      r     = '0;
      zeros = 0;
      for (int i = 0; i < LANES; i++) begin
         if (!mask[i]) begin
            zeros++;
            r.lane = 2'(i);
         end
      end
      r.valid = (zeros == 1);
      return r;
   endfunction

endpackage

// File: rtl/lenet_argmax_if.sv
// Snoop/control/result bundle between the LeNet core and the classifier stage.
interface lenet_argmax_if #(
   parameter int LOGIT_W = 8
);
   logic               conv_start;
   logic               fc2_done;
   logic               sram_write_enable_f;
   logic [3:0]         sram_bytemask_f;
   logic [1:0]         sram_waddr_f;
   logic [LOGIT_W-1:0] sram_wdata_f;
   logic [LOGIT_W-1:0] sram_wdata_f_1;
   logic               result_ready;
   logic               result_valid;
   logic [3:0]         class0;
   logic [3:0]         class1;
   logic [LOGIT_W-1:0] score0;
   logic [LOGIT_W-1:0] score1;
   logic               result_err;
   logic               busy;

   modport master (
      output conv_start, fc2_done, sram_write_enable_f, sram_bytemask_f,
             sram_waddr_f, sram_wdata_f, sram_wdata_f_1, result_ready,
      input  result_valid, class0, class1, score0, score1, result_err, busy
   );

   modport slave (
      input  conv_start, fc2_done, sram_write_enable_f, sram_bytemask_f,
             sram_waddr_f, sram_wdata_f, sram_wdata_f_1, result_ready,
      output result_valid, class0, class1, score0, score1, result_err, busy
   );
endinterface

// File: rtl/lenet_argmax_scan.sv
// One image set: logit register file plus the running signed argmax.
module lenet_argmax_scan import lenet_argmax_pkg::*; #(
   parameter int NUM_CLASS = lenet_argmax_pkg::NUM_CLASS,
   parameter int LOGIT_W   = lenet_argmax_pkg::LOGIT_W
) (
   input  logic                      clk,
   input  logic                      srstn,
   input  logic                      wr_en,
   input  logic [3:0]                wr_idx,
   input  logic [LOGIT_W-1:0]        wr_data,
   input  logic                      scan_en,
   input  logic [3:0]                scan_k,
   output logic signed [LOGIT_W-1:0] best_nxt,
   output logic [3:0]                bidx_nxt
);

   logic signed [LOGIT_W-1:0] logit [NUM_CLASS];
   logic signed [LOGIT_W-1:0] best;
   logic [3:0]                bidx;
   logic signed [LOGIT_W-1:0] cur;

   // Select logit[k] and form the next running best; strict > keeps the lowest index on ties.
   always_comb begin
      cur = '0;
      for (int i = 0; i < NUM_CLASS; i++) begin
         if (scan_k == 4'(i)) cur = logit[i];
      end
      best_nxt = best;
      bidx_nxt = bidx;
      if (scan_k == 4'd0) begin
         best_nxt = cur;
         bidx_nxt = 4'd0;
      end else if (cur > best) begin
         best_nxt = cur;
         bidx_nxt = scan_k;
      end
   end

   // Capture snooped logits and advance the running best while scanning.
   always_ff @(posedge clk) begin
      if (!srstn) begin
         for (int i = 0; i < NUM_CLASS; i++) logit[i] <= '0;
         best <= '0;
         bidx <= '0;
      end else begin
         for (int i = 0; i < NUM_CLASS; i++) begin
            if (wr_en && (wr_idx == 4'(i))) logit[i] <= wr_data;
         end
         if (scan_en) begin
            best <= best_nxt;
            bidx <= bidx_nxt;
         end
      end
   end

endmodule

// File: rtl/lenet_argmax.sv
// Classifier output stage: snoops FC2 logits for both sets, resolves argmax, hands off result.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for conv_start; writes and fc2_done ignored
// ST_COLLECT | capturing logits from SRAM F writes until fc2_done
// ST_RESOLVE | scanning k = 0..NUM_CLASS-1 in both sets, one logit/cycle
// ST_HOLD    | result_valid high, outputs frozen until result_ready
module lenet_argmax import lenet_argmax_pkg::*; #(
   parameter int NUM_CLASS = lenet_argmax_pkg::NUM_CLASS,
   parameter int LOGIT_W   = lenet_argmax_pkg::LOGIT_W
) (
   input  logic           clk,
   input  logic           srstn,
   lenet_argmax_if.slave  bus
);

   localparam logic [3:0] IDX_LIM = 4'(NUM_CLASS);
   localparam logic [3:0] K_LAST  = 4'(NUM_CLASS - 1);

   state_t                    state;
   logic [3:0]                scan_k;
   logic [NUM_CLASS-1:0]      seen;
   logic [NUM_CLASS-1:0]      seen_set;
   logic                      bad;
   lane_sel_t                 lsel;
   logic [3:0]                wr_idx;
   logic                      wr_act;
   logic                      wr_cap;
   logic                      wr_bad;
   logic                      scan_en;
   logic signed [LOGIT_W-1:0] best_nxt0;
   logic signed [LOGIT_W-1:0] best_nxt1;
   logic [3:0]                bidx_nxt0;
   logic [3:0]                bidx_nxt1;

   // Classify the snooped write; idx = addr*4 + lane is just the concatenation.
   // A write coinciding with an abort is discarded along with the frame.
   always_comb begin
      lsel    = lane_of(bus.sram_bytemask_f);
      wr_idx  = {bus.sram_waddr_f, lsel.lane};
      wr_act  = (state == ST_COLLECT) && !bus.sram_write_enable_f && !bus.conv_start;
      wr_cap  = wr_act && lsel.valid && (wr_idx < IDX_LIM);
      wr_bad  = wr_act && !lsel.valid;
      scan_en = (state == ST_RESOLVE) && !bus.conv_start;
   end

   // One-hot of the logit slot being filled this cycle.
   always_comb begin
      seen_set = '0;
      for (int i = 0; i < NUM_CLASS; i++) begin
         seen_set[i] = wr_cap && (wr_idx == 4'(i));
      end
   end

   lenet_argmax_scan #(.NUM_CLASS(NUM_CLASS), .LOGIT_W(LOGIT_W)) u_scan0 (
      .clk      (clk),
      .srstn    (srstn),
      .wr_en    (wr_cap),
      .wr_idx   (wr_idx),
      .wr_data  (bus.sram_wdata_f),
      .scan_en  (scan_en),
      .scan_k   (scan_k),
      .best_nxt (best_nxt0),
      .bidx_nxt (bidx_nxt0)
   );

   lenet_argmax_scan #(.NUM_CLASS(NUM_CLASS), .LOGIT_W(LOGIT_W)) u_scan1 (
      .clk      (clk),
      .srstn    (srstn),
      .wr_en    (wr_cap),
      .wr_idx   (wr_idx),
      .wr_data  (bus.sram_wdata_f_1),
      .scan_en  (scan_en),
      .scan_k   (scan_k),
      .best_nxt (best_nxt1),
      .bidx_nxt (bidx_nxt1)
   );

   // Frame sequencing with registered handshake outputs; conv_start outranks everything but reset.
   always_ff @(posedge clk) begin
      if (!srstn) begin
         state            <= ST_IDLE;
         scan_k           <= '0;
         seen             <= '0;
         bad              <= 1'b0;
         bus.result_valid <= 1'b0;
         bus.class0       <= '0;
         bus.class1       <= '0;
         bus.score0       <= '0;
         bus.score1       <= '0;
         bus.result_err   <= 1'b0;
         bus.busy         <= 1'b0;
      end else if (bus.conv_start) begin
         state            <= ST_COLLECT;
         scan_k           <= '0;
         seen             <= '0;
         bad              <= 1'b0;
         bus.result_valid <= 1'b0;
         bus.busy         <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               bus.busy <= 1'b0;
            end
            ST_COLLECT: begin
               seen <= seen | seen_set;
               if (wr_bad) bad <= 1'b1;
               if (bus.fc2_done) begin
                  state  <= ST_RESOLVE;
                  scan_k <= '0;
               end
            end
            ST_RESOLVE: begin
               if (scan_k == K_LAST) begin
                  state            <= ST_HOLD;
                  scan_k           <= '0;
                  bus.class0       <= bidx_nxt0;
                  bus.class1       <= bidx_nxt1;
                  bus.score0       <= best_nxt0;
                  bus.score1       <= best_nxt1;
                  bus.result_err   <= (~&seen) | bad;
                  bus.result_valid <= 1'b1;
                  bus.busy         <= 1'b0;
               end else begin
                  scan_k <= scan_k + 4'd1;
               end
            end
            ST_HOLD: begin
               if (bus.result_valid && bus.result_ready) begin
                  state            <= ST_IDLE;
                  bus.result_valid <= 1'b0;
               end
            end
            default: begin
               state    <= ST_IDLE;
               bus.busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lenet_argmax.sv
// Directed bench for lenet_argmax with a result scoreboard and a small logit model.
module tb_lenet_argmax;

   logic clk   = 1'b0;
   logic srstn = 1'b0;

   always #5 clk = ~clk;

   lenet_argmax_if bus ();

   lenet_argmax dut (
      .clk   (clk),
      .srstn (srstn),
      .bus   (bus)
   );

   typedef struct packed {
      logic [3:0] c0;
      logic [7:0] s0;
      logic [3:0] c1;
      logic [7:0] s1;
      logic       err;
   } res_t;

   res_t exp_q[$];
   int   tests  = 0;
   int   failed = 0;

   logic signed [7:0] m0 [10];
   logic signed [7:0] m1 [10];
   logic [9:0]        mseen;
   logic              mbad;

   int a0 [10] = '{-5, 3, 7, 2, 7, -128, 0, 1, 6, 4};
   int a1 [10] = '{127, 100, 90, 80, 70, 60, 50, 40, 30, 0};
   int b1 [10] = '{1, 2, 3, 5, 4, 0, -1, 2, 5, -7};
   int c0 [10] = '{10, 20, 30, 40, 50, 5, 5, 0, 5, 5};
   int c1 [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 9, 0};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic res_t cur_res();
      res_t r;
      r.c0  = bus.class0;
      r.s0  = bus.score0;
      r.c1  = bus.class1;
      r.s1  = bus.score1;
      r.err = bus.result_err;
      return r;
   endfunction

   function automatic res_t model_res();
      res_t              r;
      logic signed [7:0] b0, b1v;
      int                i0, i1;
      b0 = m0[0]; i0 = 0;
      b1v = m1[0]; i1 = 0;
      for (int i = 1; i < 10; i++) begin
         if (m0[i] > b0)  begin b0  = m0[i]; i0 = i; end
         if (m1[i] > b1v) begin b1v = m1[i]; i1 = i; end
      end
      r.c0  = 4'(i0);
      r.s0  = b0;
      r.c1  = 4'(i1);
      r.s1  = b1v;
      r.err = (mseen != 10'h3FF) | mbad;
      return r;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 10; i++) begin
         m0[i] = '0;
         m1[i] = '0;
      end
      mseen = '0;
      mbad  = 1'b0;
   endtask

   task automatic raw_write(input logic [1:0] a, input logic [3:0] mask,
                            input logic [7:0] d0, input logic [7:0] d1);
      int lane;
      int idx;
      lane = 0;
      bus.sram_waddr_f        = a;
      bus.sram_bytemask_f     = mask;
      bus.sram_wdata_f        = d0;
      bus.sram_wdata_f_1      = d1;
      bus.sram_write_enable_f = 1'b0;
      if ($countones(~mask) == 1) begin
         for (int l = 0; l < 4; l++) if (!mask[l]) lane = l;
         idx = int'(a) * 4 + lane;
         if (idx < 10) begin
            m0[idx]    = d0;
            m1[idx]    = d1;
            mseen[idx] = 1'b1;
         end
      end else begin
         mbad = 1'b1;
      end
      tick();
      bus.sram_write_enable_f = 1'b1;
      bus.sram_bytemask_f     = 4'hF;
   endtask

   task automatic write_logit(input int idx, input int d0, input int d1);
      logic [3:0] one;
      one = 4'b0001;
      raw_write(2'(idx / 4), ~(one << (idx % 4)), 8'(d0), 8'(d1));
   endtask

   task automatic start_frame();
      bus.conv_start = 1'b1;
      tick();
      bus.conv_start = 1'b0;
      mseen = '0;
      mbad  = 1'b0;
   endtask

   task automatic pulse_fc2(input bit push);
      bus.fc2_done = 1'b1;
      tick();
      bus.fc2_done = 1'b0;
      if (push) exp_q.push_back(model_res());
   endtask

   task automatic wait_result(output res_t got);
      res_t exp;
      int   n;
      n = 0;
      while (bus.result_valid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check("latency", n, 10);
      got = cur_res();
      check("sb_depth", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
         exp = exp_q.pop_front();
         check("class0", got.c0, exp.c0);
         check("score0", got.s0, exp.s0);
         check("class1", got.c1, exp.c1);
         check("score1", got.s1, exp.s1);
         check("result_err", got.err, exp.err);
      end
   endtask

   task automatic release_result();
      bus.result_ready = 1'b1;
      tick();
      check("valid_drop", bus.result_valid, 0);
      check("busy_idle", bus.busy, 0);
      bus.result_ready = 1'b0;
   endtask

   res_t got;
   bit   any_v;
   bit   any_busy;

   initial begin
      bus.conv_start          = 1'b0;
      bus.fc2_done            = 1'b0;
      bus.sram_write_enable_f = 1'b1;
      bus.sram_bytemask_f     = 4'hF;
      bus.sram_waddr_f        = '0;
      bus.sram_wdata_f        = '0;
      bus.sram_wdata_f_1      = '0;
      bus.result_ready        = 1'b0;
      model_clear();
      tick();
      tick();
      check("rst_valid", bus.result_valid, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_outs", cur_res(), 0);
      srstn = 1'b1;
      tick();

      // Frame A: reference logits, plus writes to idx 10 and address 3 that must be dropped.
      start_frame();
      check("A_busy", bus.busy, 1);
      for (int i = 0; i < 10; i++) write_logit(i, a0[i], a1[i]);
      raw_write(2'd2, 4'b1011, 8'h7F, 8'h7F);
      raw_write(2'd3, 4'b1110, 8'h7F, 8'h7F);
      pulse_fc2(1);
      check("A_busy_resolve", bus.busy, 1);
      wait_result(got);
      check("A_class0", bus.class0, 2);
      check("A_score0", bus.score0, 7);
      check("A_class1", bus.class1, 0);
      check("A_score1", bus.score1, 8'h7F);
      check("A_err", bus.result_err, 0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hold_valid", bus.result_valid, 1);
         check("hold_stable", cur_res(), got);
         check("hold_busy", bus.busy, 0);
      end
      release_result();

      // Frame B: all -128 in set 0, a rewrite, and a tie in set 1; ready already high.
      start_frame();
      for (int i = 0; i < 10; i++) write_logit(i, -128, (i == 3) ? 50 : b1[i]);
      write_logit(3, -128, b1[3]);
      bus.result_ready = 1'b1;
      pulse_fc2(1);
      wait_result(got);
      check("B_class0", got.c0, 0);
      check("B_score0", got.s0, 8'h80);
      check("B_class1", got.c1, 3);
      check("B_score1", got.s1, 5);
      tick();
      check("B_b2b_valid", bus.result_valid, 0);
      check("B_b2b_busy", bus.busy, 0);
      bus.result_ready = 1'b0;

      // Frame C: idx 7 missing and two malformed writes carrying a would-be winner.
      start_frame();
      for (int i = 0; i < 10; i++) if (i != 7) write_logit(i, c0[i], c1[i]);
      raw_write(2'd1, 4'b0011, 8'h7F, 8'h7F);
      raw_write(2'd0, 4'b1111, 8'h7F, 8'h7F);
      pulse_fc2(1);
      wait_result(got);
      check("C_class0", got.c0, 4);
      check("C_score0", got.s0, 50);
      check("C_class1", got.c1, 8);
      check("C_err", got.err, 1);
      release_result();

      // Frame D aborted during RESOLVE at k=4, then frame E resolves normally.
      start_frame();
      for (int i = 0; i < 10; i++) write_logit(i, (i == 5) ? 60 : 1, 1);
      pulse_fc2(0);
      repeat (4) tick();
      bus.conv_start = 1'b1;
      tick();
      bus.conv_start = 1'b0;
      mseen = '0;
      mbad  = 1'b0;
      check("abort_busy", bus.busy, 1);
      any_v = 1'b0;
      for (int i = 0; i < 12; i++) begin
         any_v |= bus.result_valid;
         tick();
      end
      check("abort_no_valid", any_v, 0);
      for (int i = 0; i < 10; i++) write_logit(i, i * 3 - 10, 20 - i * 2);
      pulse_fc2(1);
      wait_result(got);
      check("E_class0", got.c0, 9);
      check("E_score0", got.s0, 17);
      check("E_class1", got.c1, 0);
      check("E_score1", got.s1, 20);
      release_result();

      // Reset mid-COLLECT: everything cleared, stray fc2_done ignored.
      start_frame();
      write_logit(0, 99, 99);
      srstn = 1'b0;
      tick();
      srstn = 1'b1;
      model_clear();
      check("mid_rst_busy", bus.busy, 0);
      check("mid_rst_valid", bus.result_valid, 0);
      check("mid_rst_outs", cur_res(), 0);
      pulse_fc2(0);
      any_v    = 1'b0;
      any_busy = 1'b0;
      for (int i = 0; i < 12; i++) begin
         any_v    |= bus.result_valid;
         any_busy |= bus.busy;
         tick();
      end
      check("idle_fc2_valid", any_v, 0);
      check("idle_fc2_busy", any_busy, 0);

      // Frame F: no writes after reset, so zeroed logits and an incomplete frame.
      start_frame();
      pulse_fc2(1);
      wait_result(got);
      check("F_score0", got.s0, 0);
      check("F_err", got.err, 1);
      release_result();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/lenet_argmax.md
# lenet_argmax

Classifier output stage downstream of the two-set LeNet core. It snoops the FC2 result writes on the SRAM F write port, capturing 10 signed 8-bit logits per image for both image sets (`sram_wdata_f` and `sram_wdata_f_1`). After `fc2_done`, it scans the logits to find the winning class. It then presents the predicted digit and winning score for both images through a valid/ready handshake.

## Interface
Parameters:
- `NUM_CLASS`, default 10: number of logits per image (indices 0..NUM_CLASS-1).
- `LOGIT_W`, default 8: logit width, two's complement.

Ports:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `srstn`, in, 1: reset, synchronous, active-low.
- `conv_start`, in, 1: start of a new frame; clears capture state.
- `fc2_done`, in, 1: single-cycle pulse; the FC2 layer is complete.
- `sram_write_enable_f`, in, 1: SRAM F write enable, active-low.
- `sram_bytemask_f`, in, 4: byte-lane mask, active-low (0 = lane written).
- `sram_waddr_f`, in, 2: SRAM F word address.
- `sram_wdata_f`, in, 8: set-0 logit.
- `sram_wdata_f_1`, in, 8: set-1 logit.
- `result_ready`, in, 1: consumer accepts the result.
- `result_valid`, out, 1: result held stable while high.
- `class0`, `class1`, out, 4 each: predicted digit for set 0 and set 1.
- `score0`, `score1`, out, 8 each: winning logit for set 0 and set 1.
- `result_err`, out, 1: frame incomplete or malformed.
- `busy`, out, 1: high in COLLECT and RESOLVE.

## Operation
- States: IDLE, COLLECT, RESOLVE, HOLD.
- IDLE → COLLECT on `conv_start`. Writes and `fc2_done` are ignored in IDLE.
- COLLECT, write accepted when `sram_write_enable_f`==0 and `sram_bytemask_f` has exactly one 0 bit:
  - lane = position of the 0 bit; idx = `sram_waddr_f`*4 + lane.
  - If idx < NUM_CLASS: store `sram_wdata_f` into logit0[idx] and `sram_wdata_f_1` into logit1[idx], and set seen[idx].
  - idx 10, 11 and address 3 are dropped silently, with no error.
  - A rewrite of the same idx overwrites; last write wins.
- COLLECT, malformed mask (write enabled, zero or ≥2 lanes active): the write is dropped and the sticky `bad` flag is set.
- COLLECT → RESOLVE on `fc2_done`. A write in the same cycle as `fc2_done` is still captured.
- RESOLVE: per set, 4-bit scan counter k runs 0..NUM_CLASS-1, one logit per cycle.
  - At k=0: best = logit[0], bidx = 0.
  - At k>0: replace best and bidx only if logit[k] > best (signed, strict), so ties resolve to the lowest index.
  - Sets 0 and 1 are scanned in parallel.
- RESOLVE → HOLD after k=NUM_CLASS-1. On that edge:
  - load `class*` and `score*`;
  - set `result_err` = (seen != all-ones) | bad;
  - assert `result_valid`.
- HOLD: outputs stay frozen. When `result_valid` and `result_ready` are both high, go to IDLE, with `result_valid` low the next cycle.
- `conv_start` in COLLECT, RESOLVE or HOLD aborts the current frame:
  - next state COLLECT;
  - seen, bad and k cleared;
  - `result_valid` dropped;
  - logits not cleared.
- `conv_start` has priority over `fc2_done` and over the handshake.
- Reset (`srstn`==0 at an edge):
  - state IDLE;
  - all outputs 0;
  - logits, seen, bad and k cleared.

## Timing
- `fc2_done` high at edge T: RESOLVE occupies cycles T+1..T+10, and `result_valid` rises after edge T+10 (10 cycles of RESOLVE).
- Capture latency: a logit write is registered on the same edge it is presented.
- `busy` is registered and matches the state: 1 in COLLECT and RESOLVE, 0 in IDLE and HOLD.
- Throughput: one frame per `conv_start`. Back-to-back acceptance is allowed: `result_ready` high while `result_valid` rises releases HOLD on the next edge.

## Structure
- `lenet_argmax_pkg` holds:
  - the state enum (IDLE, COLLECT, RESOLVE, HOLD);
  - NUM_CLASS, LOGIT_W and LANES=4;
  - the function `lane_of(mask)` returning the lane index plus a one-hot-valid flag.
- Sub-module `lenet_argmax_scan` contains one set's logit register file, running best/bidx and compare. It is instantiated twice (set 0, set 1), sharing k and control from the top-level FSM.

## Test plan
- Set-0 logits idx0..9 = {-5,3,7,2,7,-128,0,1,6,4}, set 1 = {127,...,0}, each written via the proper address/lane, then `fc2_done` → after 10 cycles `class0`=2, `score0`=7, `class1`=0, `score1`=127, `result_err`=0.
- Set-0 logits all -128 → `class0`=0, `score0`=-128 (tie resolves to the lowest index).
- Idx 7 never written, plus one write with `sram_bytemask_f`=4'b0011 → result produced with `result_err`=1, and the malformed write does not alter any logit.
- Hold `result_ready` low for 5 cycles after `result_valid` → outputs stable and state stays HOLD; raise `result_ready` → `result_valid` low next cycle, `busy`=0.
- `conv_start` during RESOLVE at k=4 → `result_valid` never asserts; new frame collects correctly and resolves to new values.
- `srstn` low for one edge mid-COLLECT → all outputs 0, state IDLE; a later `fc2_done` without `conv_start` is ignored.
